// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - word-addressed program counter with boot/run/halt sequencing
// and an optional single branch delay slot.
module pc_sequencer #(
  parameter logic [29:0] RESET_VECTOR = 30'h0000_0000,
  parameter int          DELAY_SLOT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic [29:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [29:0] pc,
  output logic [31:0] pc_byte,
  output logic [29:0] pc_plus1,
  output logic        fetch_valid,
  output logic        redirect_pending,
  output logic        misaligned,
  output logic [1:0]  state
);

  localparam logic [1:0] ST_BOOT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [29:0] tgt_q, tgt_d;
  logic        pend_q, pend_d;
  logic        mis_q, mis_d;

  logic        redirect;
  logic [29:0] target;

  assign pc_plus1 = pc_q + 30'd1;

  // Only the highest-priority redirect contributes a target.
  always_comb begin
    redirect = jump_reg | jump | branch_taken;
    if (jump_reg) begin
      target = reg_target[31:2];
    end else if (jump) begin
      target = {pc_plus1[29:26], jump_target};
    end else begin
      target = pc_plus1 + branch_offset;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;
    mis_d   = mis_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALT;
          pend_d  = 1'b0;
          tgt_d   = 30'd0;
        end else if (!stall) begin
          if (pend_q) begin
            // Delay slot has issued; any redirect presented now is dropped.
            pc_d   = tgt_q;
            pend_d = 1'b0;
          end else if (redirect) begin
            if (jump_reg && (reg_target[1:0] != 2'b00)) begin
              mis_d = 1'b1;
            end
            if (DELAY_SLOT != 0) begin
              pc_d   = pc_plus1;
              pend_d = 1'b1;
              tgt_d  = target;
            end else begin
              pc_d = target;
            end
          end else begin
            pc_d = pc_plus1;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      tgt_q   <= 30'd0;
      pend_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      mis_q   <= mis_d;
    end
  end

  assign pc               = pc_q;
  assign pc_byte          = {pc_q, 2'b00};
  assign fetch_valid      = (state_q == ST_RUN);
  assign redirect_pending = pend_q;
  assign misaligned       = mis_q;
  assign state            = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - bench for pc_sequencer with and without a delay slot.
module tb_pc_sequencer;

  typedef struct packed {
    logic        stall;
    logic        halt;
    logic        br;
    logic [29:0] off;
    logic        j;
    logic [25:0] jt;
    logic        jr;
    logic [31:0] rt;
  } in_t;

  typedef struct {
    logic [29:0] pc;
    logic        pend;
    logic [29:0] tgt;
    logic        mis;
    int          st;
  } model_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  in_t  ia, ib;
  model_t ma, mb;
  int n_vec = 0;
  int n_err = 0;

  logic [29:0] a_pc, b_pc, a_pp1, b_pp1;
  logic [31:0] a_pcb, b_pcb;
  logic        a_fv, b_fv, a_pend, b_pend, a_mis, b_mis;
  logic [1:0]  a_st, b_st;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(30'h0), .DELAY_SLOT(1)) dut_a (
    .clk(clk), .reset(reset), .stall(ia.stall), .halt(ia.halt),
    .branch_taken(ia.br), .branch_offset(ia.off), .jump(ia.j),
    .jump_target(ia.jt), .jump_reg(ia.jr), .reg_target(ia.rt),
    .pc(a_pc), .pc_byte(a_pcb), .pc_plus1(a_pp1), .fetch_valid(a_fv),
    .redirect_pending(a_pend), .misaligned(a_mis), .state(a_st));

  pc_sequencer #(.RESET_VECTOR(30'h0), .DELAY_SLOT(0)) dut_b (
    .clk(clk), .reset(reset), .stall(ib.stall), .halt(ib.halt),
    .branch_taken(ib.br), .branch_offset(ib.off), .jump(ib.j),
    .jump_target(ib.jt), .jump_reg(ib.jr), .reg_target(ib.rt),
    .pc(b_pc), .pc_byte(b_pcb), .pc_plus1(b_pp1), .fetch_valid(b_fv),
    .redirect_pending(b_pend), .misaligned(b_mis), .state(b_st));

  function automatic model_t mreset();
    model_t m;
    m.pc = 30'h0; m.pend = 1'b0; m.tgt = 30'h0; m.mis = 1'b0; m.st = 0;
    return m;
  endfunction

  // One clock edge of the architectural rules: st 0=boot, 1=run, 2=halted.
  function automatic model_t mstep(model_t m, in_t i, bit ds);
    model_t n = m;
    logic [29:0] t, nxt;
    nxt = m.pc + 30'd1;
    if (m.st == 0) begin
      n.st = 1;
    end else if (m.st == 1) begin
      if (i.halt) begin
        n.st = 2; n.pend = 1'b0; n.tgt = 30'h0;
      end else if (!i.stall) begin
        if (m.pend) begin
          n.pc = m.tgt; n.pend = 1'b0;
        end else if (i.jr || i.j || i.br) begin
          if (i.jr) begin
            t = i.rt[31:2];
            if (i.rt[1:0] != 2'b00) n.mis = 1'b1;
          end else if (i.j) begin
            t = {nxt[29:26], i.jt};
          end else begin
            t = m.pc + 30'd1 + i.off;
          end
          if (ds) begin n.pc = nxt; n.pend = 1'b1; n.tgt = t; end
          else n.pc = t;
        end else begin
          n.pc = nxt;
        end
      end
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    ma = mstep(ma, ia, 1'b1);
    mb = mstep(mb, ib, 1'b0);
    #1;
  endtask

  task automatic idle();
    ia = '0;
    ib = '0;
  endtask

  // Land both instances on word address x after two edges.
  task automatic goto(input logic [29:0] x);
    logic [29:0] xm1;
    xm1 = x - 30'd1;
    idle();
    ia.jr = 1'b1; ia.rt = {x, 2'b00};
    ib.jr = 1'b1; ib.rt = {xm1, 2'b00};
    tick();
    idle();
    tick();
    n_vec++;
    if (a_pc !== x || b_pc !== x) begin
      n_err++;
      $display("FAIL goto: a_pc=%h b_pc=%h expected %h", a_pc, b_pc, x);
    end
  endtask

  task automatic reset_pulse();
    #3 reset = 1'b1;
    #1;
    ma = mreset();
    mb = mreset();
    n_vec++;
    if (a_pc !== 30'h0 || a_fv !== 1'b0 || a_st !== 2'b00 || a_pend !== 1'b0 ||
        a_mis !== 1'b0 || b_pc !== 30'h0 || b_fv !== 1'b0 || b_st !== 2'b00) begin
      n_err++;
      $display("FAIL async_reset: a pc=%h fv=%b st=%b pend=%b mis=%b b pc=%h fv=%b st=%b required 0/0/00/0/0",
               a_pc, a_fv, a_st, a_pend, a_mis, b_pc, b_fv, b_st);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    ma = mreset();
    mb = mreset();
    #1;
    n_vec++;
    if (a_pc !== 30'h0 || a_st !== 2'b00 || a_fv !== 1'b0 || a_pend !== 1'b0 || a_mis !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: pc=%h st=%b fv=%b pend=%b mis=%b required 0", a_pc, a_st, a_fv, a_pend, a_mis);
    end
    #1 reset = 1'b0;
    ia.halt = 1'b1; ia.jr = 1'b1; ia.rt = 32'h100;
    tick();
    n_vec++;
    if (a_st !== 2'b01 || a_pc !== 30'h0 || a_fv !== 1'b1) begin
      n_err++;
      $display("FAIL boot_ignores_inputs: st=%b pc=%h fv=%b required 01/0/1", a_st, a_pc, a_fv);
    end
    idle();
    tick();
    tick();
    goto(30'h25);
    reset_pulse();
    tick();
    n_vec++;
    if (a_st !== 2'b01 || a_pc !== 30'h0 || a_fv !== 1'b1) begin
      n_err++;
      $display("FAIL reset_edge1: st=%b pc=%h fv=%b required 01/0/1", a_st, a_pc, a_fv);
    end
    tick();
    n_vec++;
    if (a_pc !== 30'h1) begin n_err++; $display("FAIL reset_edge2: pc=%h required 1", a_pc); end
    tick();
    n_vec++;
    if (a_pc !== 30'h2 || a_pcb !== 32'h8 || a_pp1 !== 30'h3) begin
      n_err++;
      $display("FAIL reset_edge3: pc=%h pcb=%h pp1=%h required 2/8/3", a_pc, a_pcb, a_pp1);
    end
  endtask

  task automatic test_branch();
    goto(30'h10);
    ia.br = 1'b1; ia.off = 30'h3FFF_FFFC;
    ib.br = 1'b1; ib.off = 30'h3FFF_FFFC;
    tick();
    idle();
    n_vec++;
    if (a_pc !== 30'h11 || a_pend !== 1'b1) begin
      n_err++; $display("FAIL branch_slot: pc=%h pend=%b required 11/1", a_pc, a_pend);
    end
    n_vec++;
    if (b_pc !== 30'h0D || b_pend !== 1'b0) begin
      n_err++; $display("FAIL branch_noslot: pc=%h pend=%b required 0d/0", b_pc, b_pend);
    end
    tick();
    n_vec++;
    if (a_pc !== 30'h0D || a_pend !== 1'b0) begin
      n_err++; $display("FAIL branch_target: pc=%h pend=%b required 0d/0", a_pc, a_pend);
    end
  endtask

  task automatic test_jump();
    goto(30'h3C00_0005);
    ia.j = 1'b1; ia.jt = 26'h000_0100;
    tick();
    idle();
    n_vec++;
    if (a_pc !== 30'h3C00_0006) begin n_err++; $display("FAIL jump_slot: pc=%h required 3c000006", a_pc); end
    tick();
    n_vec++;
    if (a_pc !== 30'h3C00_0100) begin n_err++; $display("FAIL jump_target: pc=%h required 3c000100", a_pc); end
  endtask

  task automatic test_jr_priority();
    goto(30'h40);
    ia.jr = 1'b1; ia.br = 1'b1; ia.off = 30'h5; ia.rt = 32'h0000_0403;
    ib = ia;
    tick();
    idle();
    n_vec++;
    if (a_pc !== 30'h41 || a_pend !== 1'b1 || a_mis !== 1'b1) begin
      n_err++; $display("FAIL jr_slot: pc=%h pend=%b mis=%b required 41/1/1", a_pc, a_pend, a_mis);
    end
    n_vec++;
    if (b_pc !== 30'h100 || b_mis !== 1'b1) begin
      n_err++; $display("FAIL jr_noslot: pc=%h mis=%b required 100/1", b_pc, b_mis);
    end
    ia.br = 1'b1; ia.off = 30'h7;
    tick();
    idle();
    n_vec++;
    if (a_pc !== 30'h100 || a_pend !== 1'b0 || a_mis !== 1'b1) begin
      n_err++; $display("FAIL jr_target: pc=%h pend=%b mis=%b required 100/0/1", a_pc, a_pend, a_mis);
    end
  endtask

  task automatic test_stall();
    goto(30'h200);
    ia.br = 1'b1; ia.off = 30'h20;
    tick();
    ia.stall = 1'b1; ia.br = 1'b1; ia.off = 30'h3;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (a_pc !== 30'h201 || a_pend !== 1'b1) begin
        n_err++; $display("FAIL stall_hold%0d: pc=%h pend=%b required 201/1", k, a_pc, a_pend);
      end
    end
    idle();
    tick();
    n_vec++;
    if (a_pc !== 30'h221 || a_pend !== 1'b0 || a_mis !== 1'b1) begin
      n_err++; $display("FAIL stall_release: pc=%h pend=%b mis=%b required 221/0/1", a_pc, a_pend, a_mis);
    end
  endtask

  task automatic test_wrap_halt();
    goto(30'h3FFF_FFFF);
    tick();
    n_vec++;
    if (a_pc !== 30'h0 || a_pcb !== 32'h0 || b_pc !== 30'h0 || b_pcb !== 32'h0) begin
      n_err++; $display("FAIL wrap: a_pc=%h a_pcb=%h b_pc=%h b_pcb=%h required 0", a_pc, a_pcb, b_pc, b_pcb);
    end
    ia.halt = 1'b1; ia.stall = 1'b1;
    ib = ia;
    tick();
    n_vec++;
    if (a_st !== 2'b10 || a_fv !== 1'b0 || a_pc !== 30'h0 || b_st !== 2'b10) begin
      n_err++; $display("FAIL halt_enter: st=%b fv=%b pc=%h b_st=%b required 10/0/0/10", a_st, a_fv, a_pc, b_st);
    end
    for (int k = 0; k < 10; k++) begin
      ia = '0; ia.jr = 1'b1; ia.rt = $urandom; ia.halt = $urandom_range(0, 1);
      ib = ia;
      tick();
      n_vec++;
      if (a_pc !== 30'h0 || a_st !== 2'b10 || a_fv !== 1'b0 || a_pend !== 1'b0) begin
        n_err++; $display("FAIL halt_frozen%0d: pc=%h st=%b fv=%b pend=%b", k, a_pc, a_st, a_fv, a_pend);
      end
    end
    idle();
    reset_pulse();
    tick();
  endtask

  task automatic test_random();
    in_t r;
    for (int k = 0; k < 400; k++) begin
      for (int s = 0; s < 2; s++) begin
        r = '0;
        r.stall = ($urandom_range(0, 3) == 0);
        r.halt  = ($urandom_range(0, 79) == 0);
        r.br    = ($urandom_range(0, 3) == 0);
        r.off   = $urandom;
        r.j     = ($urandom_range(0, 5) == 0);
        r.jt    = $urandom;
        r.jr    = ($urandom_range(0, 5) == 0);
        r.rt    = $urandom;
        if (s == 0) ia = r; else ib = r;
      end
      tick();
      n_vec++;
      if (a_pc !== ma.pc || a_pcb !== {ma.pc, 2'b00} || a_pp1 !== ma.pc + 30'd1 ||
          a_pend !== ma.pend || a_mis !== ma.mis || a_st !== 2'(ma.st) || a_fv !== (ma.st == 1)) begin
        n_err++;
        $display("FAIL rand_a%0d: pc=%h pend=%b mis=%b st=%b fv=%b required %h/%b/%b/%0d", k,
                 a_pc, a_pend, a_mis, a_st, a_fv, ma.pc, ma.pend, ma.mis, ma.st);
      end
      n_vec++;
      if (b_pc !== mb.pc || b_pcb !== {mb.pc, 2'b00} || b_pp1 !== mb.pc + 30'd1 ||
          b_pend !== mb.pend || b_mis !== mb.mis || b_st !== 2'(mb.st) || b_fv !== (mb.st == 1)) begin
        n_err++;
        $display("FAIL rand_b%0d: pc=%h pend=%b mis=%b st=%b fv=%b required %h/%b/%b/%0d", k,
                 b_pc, b_pend, b_mis, b_st, b_fv, mb.pc, mb.pend, mb.mis, mb.st);
      end
      if ((ma.st == 2 && mb.st == 2) || k % 100 == 99) begin
        idle();
        reset_pulse();
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_jr_priority();
    test_stall();
    test_wrap_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter stage of the single-cycle MIPS datapath. Consumes the 30-bit sign-extended word offset produced by the immediate sign-extender, plus jump and jump-register targets. Holds the word-addressed PC and sequences fetch through boot, run, stall, branch-delay-slot and halt conditions. Feeds instruction memory (pc_byte) and the link/branch logic (pc_plus1).

Parameters:
RESET_VECTOR, 30'h0000_0000, word address loaded on reset.
DELAY_SLOT, 1, 1 means one architectural branch delay slot; 0 means redirect takes effect on the next edge.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC and pending state this cycle
halt  in  1  enter HALTED at the next edge (sticky until reset)
branch_taken  in  1  conditional branch resolved taken
branch_offset  in  30  sign-extended word offset, two's complement
jump  in  1  J/JAL request
jump_target  in  26  instr[25:0] word target
jump_reg  in  1  JR/JALR request
reg_target  in  32  register byte address for JR
pc  out  30  current fetch word address
pc_byte  out  32  {pc, 2'b00}
pc_plus1  out  30  pc + 1, mod 2^30
fetch_valid  out  1  instruction at pc is to be executed
redirect_pending  out  1  delay-slot redirect stored
misaligned  out  1  sticky: JR target had reg_target[1:0] != 0
state  out  2  00 BOOT, 01 RUN, 10 HALTED

Behaviour:
- Reset, asynchronous and immediate, no edge needed: pc=RESET_VECTOR, state=BOOT, fetch_valid=0, redirect_pending=0, pending target=0, misaligned=0.
- BOOT: one edge after reset deasserts, go to RUN with pc unchanged. stall, halt and redirects are ignored in BOOT.
- RUN: fetch_valid=1 combinationally.
- HALTED: fetch_valid=0, pc frozen. Only reset exits HALTED.
- halt=1 in RUN (stall irrelevant): next edge gives state=HALTED, pc held, pending cleared.
- Stall in RUN (halt=0): pc, pending and misaligned hold. Redirect inputs are ignored in a stalled cycle; the decoder re-presents them.
- Redirect priority: jump_reg > jump > branch_taken. Only the winner is used.
- Target arithmetic, all mod 2^30, P = current pc:
  - branch: T = P+1+branch_offset
  - jump: T = {pc_plus1[29:26], jump_target}
  - jump_reg: T = reg_target[31:2]. If reg_target[1:0]!=0, set misaligned (sticky); the redirect still proceeds.
- DELAY_SLOT=1, accepted redirect (RUN, !stall, !halt, redirect_pending=0):
  - next pc = P+1, redirect_pending=1, store T
  - on the next non-stalled edge, pc = stored T and redirect_pending=0
- Redirect in a delay-slot cycle (redirect_pending=1): ignored, and stored T is unchanged.
- DELAY_SLOT=0: accepted redirect gives next pc = T directly. redirect_pending stays 0.
- No redirect: next pc = P+1. 30'h3FFF_FFFF wraps to 0.
- Outputs pc, pc_byte and redirect_pending come from registers. pc_plus1 and fetch_valid are combinational from registers. All changes occur at the edge; there is no same-cycle forwarding.

Test Plan:
- Async reset mid-run at pc=0x25, asserted between edges: pc=0, fetch_valid=0, state=BOOT immediately. After release: edge 1 gives RUN with pc=0 and fetch_valid=1; edges 2 and 3 give pc=1, then 2.
- DELAY_SLOT=1, pc=0x10, branch_taken=1, offset=30'h3FFF_FFFC (-4): next pc=0x11 with redirect_pending=1, then pc=0x0D with pending=0. With DELAY_SLOT=0 the same stimulus gives pc=0x0D directly.
- pc=0x3C00_0005, jump=1, jump_target=26'h000_0100 (DELAY_SLOT=1): pc sequence 0x3C00_0006, then 0x3C00_0100.
- jump_reg=1 and branch_taken=1 together, reg_target=32'h0000_0403: jump_reg wins, misaligned=1, target 0x100. A branch asserted during the delay slot is ignored, and misaligned stays 1 until reset.
- stall=1 for 3 cycles while redirect_pending=1 and branch_taken=1: pc and pending hold, branch dropped. After stall drops, pc = the original stored target.
- pc=30'h3FFF_FFFF, no redirect: next pc=0, pc_byte=0. Then halt=1 together with stall=1: state=HALTED, fetch_valid=0, pc frozen for 10 cycles, and only reset recovers.
